// File: rtl/graphics_scaled_viewer.sv
// Scaled framebuffer viewer: maps the VGA raster onto a banked image in RAM.
// Scale, origin and bank change tear-free at the frame boundary.
module graphics_scaled_viewer #(
  parameter int VGA_WIDTH      = 640,
  parameter int VGA_HEIGHT     = 480,
  parameter int COLOR_LEN      = 12,
  parameter int IMG_W_LOG2     = 7,
  parameter int IMG_H_LOG2     = 7,
  parameter int NUM_BANKS      = 2,
  parameter int MAX_SCALE_LOG2 = 3,
  parameter int RAM_LATENCY    = 2,
  parameter logic [COLOR_LEN-1:0] FILL_COLOR = 12'hfff,
  localparam int XW     = $clog2(VGA_WIDTH + 160),
  localparam int YW     = $clog2(VGA_HEIGHT + 45),
  localparam int SW     = (MAX_SCALE_LOG2 > 0) ? $clog2(MAX_SCALE_LOG2 + 1) : 1,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int AW     = BANK_W + IMG_H_LOG2 + IMG_W_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 blank,
  input  logic [XW-1:0]        vga_x,
  input  logic [YW-1:0]        vga_y,
  input  logic                 vga_hsync_in,
  input  logic                 vga_vsync_in,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [SW-1:0]        cfg_scale_log2,
  input  logic [XW-1:0]        cfg_x_org,
  input  logic [YW-1:0]        cfg_y_org,
  input  logic [BANK_W-1:0]    cfg_bank,
  output logic                 ram_readclk,
  output logic [AW-1:0]        ram_raddr,
  input  logic                 ram_outclk,
  input  logic [COLOR_LEN-1:0] ram_out,
  output logic [COLOR_LEN-1:0] vga_col,
  output logic                 vga_hsync_out,
  output logic                 vga_vsync_out,
  output logic                 frame_swap
);

  // Widened to int so the clamp stays meaningful for any SW/MAX combination.
  function automatic logic [SW-1:0] clamp_scale(input logic [SW-1:0] s);
    int v;
    v = int'(s);
    if (v > MAX_SCALE_LOG2) return SW'(MAX_SCALE_LOG2);
    else return s;
  endfunction

  logic [SW-1:0]     scale_r, pend_scale_r;
  logic [XW-1:0]     x_org_r, pend_x_org_r;
  logic [YW-1:0]     y_org_r, pend_y_org_r;
  logic [BANK_W-1:0] bank_r, pend_bank_r;
  logic              pend_valid_r, frame_swap_r;
  logic              capture_s, boundary_s;

  always_comb begin
    capture_s  = cfg_valid && !pend_valid_r;
    boundary_s = pend_valid_r && (vga_x == XW'(0)) && (vga_y == YW'(VGA_HEIGHT));
  end

  // Active/pending configuration; capture and swap are mutually exclusive on pend_valid_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      scale_r      <= SW'(2);
      x_org_r      <= '0;
      y_org_r      <= '0;
      bank_r       <= '0;
      pend_scale_r <= '0;
      pend_x_org_r <= '0;
      pend_y_org_r <= '0;
      pend_bank_r  <= '0;
      pend_valid_r <= 1'b0;
      frame_swap_r <= 1'b0;
    end else begin
      frame_swap_r <= boundary_s;
      if (boundary_s) begin
        scale_r      <= pend_scale_r;
        x_org_r      <= pend_x_org_r;
        y_org_r      <= pend_y_org_r;
        bank_r       <= pend_bank_r;
        pend_valid_r <= 1'b0;
      end else if (capture_s) begin
        pend_scale_r <= clamp_scale(cfg_scale_log2);
        pend_x_org_r <= cfg_x_org;
        pend_y_org_r <= cfg_y_org;
        pend_bank_r  <= cfg_bank;
        pend_valid_r <= 1'b1;
      end
    end
  end

  assign cfg_ready  = !pend_valid_r;
  assign frame_swap = frame_swap_r;

  logic [XW-1:0] rx_s, sx_s;
  logic [YW-1:0] ry_s, sy_s;
  logic          in_win_s;

  // Window test on full-width shifted offsets so large offsets never alias into the image.
  always_comb begin
    rx_s        = vga_x - x_org_r;
    ry_s        = vga_y - y_org_r;
    sx_s        = rx_s >> scale_r;
    sy_s        = ry_s >> scale_r;
    in_win_s    = (vga_x >= x_org_r) && (vga_y >= y_org_r) &&
                  ((sx_s >> IMG_W_LOG2) == XW'(0)) && ((sy_s >> IMG_H_LOG2) == YW'(0));
    ram_readclk = !blank && in_win_s;
    ram_raddr   = {bank_r, sy_s[IMG_H_LOG2-1:0], sx_s[IMG_W_LOG2-1:0]};
  end

  // Tap layout: {primed, hsync, vsync, blank, in_win}; primed masks the colour until the line fills.
  logic [4:0] tap_in_s, tap_out_s;

  always_comb begin
    tap_in_s = {1'b1, vga_hsync_in, vga_vsync_in, blank, in_win_s};
  end

  generate
    if (RAM_LATENCY == 0) begin : g_wire
      assign tap_out_s = tap_in_s;
    end else begin : g_pipe
      logic [4:0] stage_r [RAM_LATENCY];

      // Delay line matching RAM read latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RAM_LATENCY; i++) stage_r[i] <= '0;
        end else begin
          stage_r[0] <= tap_in_s;
          for (int i = 1; i < RAM_LATENCY; i++) stage_r[i] <= stage_r[i-1];
        end
      end

      assign tap_out_s = stage_r[RAM_LATENCY-1];
    end
  endgenerate

  always_comb begin
    vga_hsync_out = tap_out_s[3];
    vga_vsync_out = tap_out_s[2];
    if (!tap_out_s[4] || tap_out_s[1]) begin
      vga_col = '0;
    end else if (tap_out_s[0] && ram_outclk) begin
      vga_col = ram_out;
    end else begin
      vga_col = FILL_COLOR;
    end
  end

endmodule
